spi_mnrch_gen: RTL



---
 rtl/spi_mnrch_gen.sv | 132 +++++++++++++
 1 files changed

// File: rtl/spi_mnrch_gen.sv
`timescale 1ns/1ps
// spi_mnrch_gen: parametrised full-duplex SPI monarch.
// SCLK idles high, MISO is sampled as SCLK is about to rise, MSB first.
// Multi-word bursts can keep one serf selected by setting hold on each word.
// Optional build macro SPI_MNRCH_WRT_ERR_EN adds the wrt_err pulse output.
module spi_mnrch_gen #(
    parameter int DATA_W = 16,
    parameter int DIV_W  = 5,
    parameter int NUM_SS = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wrt,
    input  logic [DATA_W-1:0]         wt_data,
    input  logic [$clog2(NUM_SS)-1:0] ss_sel,
    input  logic                      hold,
    output logic [DATA_W-1:0]         rd_data,
    output logic                      done,
    output logic                      busy,
    output logic [NUM_SS-1:0]         SS_n,
    output logic                      SCLK,
    output logic                      MOSI,
    output logic [1:0]                state_dbg,
`ifdef SPI_MNRCH_WRT_ERR_EN
    output logic                      wrt_err,
`endif
    input  logic                      MISO
);

    // Handshake: wrt is a single-cycle request. It is accepted on the edge
    // where wrt=1, busy=0 and ss_sel < NUM_SS; busy rises on that edge and
    // falls on the edge that raises done. Any other wrt is dropped.

    localparam int SS_W  = $clog2(NUM_SS);
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [DIV_W-1:0] DIV_ONES     = '1;
    localparam logic [DIV_W-1:0] DIV_LOAD     = {2'b10, {(DIV_W-2){1'b1}}};
    localparam logic [DIV_W-1:0] DIV_PRE_RISE = {1'b0, {(DIV_W-1){1'b1}}};
    localparam logic [CNT_W-1:0] CNT_FULL     = CNT_W'(DATA_W);

    typedef enum logic [1:0] {IDLE = 2'd0, FRONT = 2'd1, SHIFT = 2'd2, BACK = 2'd3} state_t;

    state_t              state, state_nxt;
    logic [DIV_W-1:0]    div;
    logic [DATA_W-1:0]   shreg;
    logic [CNT_W-1:0]    bit_cnt;
    logic [SS_W-1:0]     sel_r;
    logic [SS_W-1:0]     sel_nxt;
    logic                hold_r;
    logic [NUM_SS-1:0]   ss_n_r;
    logic                accept;
    logic                shift_en;
    logic                finish;
    logic                div_run;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic: front porch, DATA_W bit slots, back porch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (accept) state_nxt = FRONT;
            FRONT: if (div == DIV_ONES) state_nxt = SHIFT;
            SHIFT: if (bit_cnt == CNT_FULL) state_nxt = BACK;
            BACK:  if (div == DIV_ONES) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output/strobe decode; a held burst keeps the previously used select.
    always_comb begin
        accept   = wrt && !busy && (32'(ss_sel) < NUM_SS);
        shift_en = (state == SHIFT) && (div == DIV_PRE_RISE);
        finish   = (state == BACK) && (div == DIV_ONES);
        div_run  = (state != IDLE) && !finish;
        sel_nxt  = hold_r ? sel_r : ss_sel;
    end

    // Datapath: divider, shift register, bit counter, status and selects.
    always_ff @(posedge clk) begin
        if (rst) begin
            div     <= DIV_ONES;
            shreg   <= '0;
            bit_cnt <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            rd_data <= '0;
            ss_n_r  <= '1;
            sel_r   <= '0;
            hold_r  <= 1'b0;
        end else if (accept) begin
            shreg   <= wt_data;
            div     <= DIV_LOAD;
            bit_cnt <= '0;
            done    <= 1'b0;
            busy    <= 1'b1;
            sel_r   <= sel_nxt;
            hold_r  <= hold;
            ss_n_r  <= ~(NUM_SS'(1) << sel_nxt);
        end else begin
            if (div_run) div <= div + 1'b1;
            if (shift_en) begin
                shreg   <= {shreg[DATA_W-2:0], MISO};
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (finish) begin
                done    <= 1'b1;
                busy    <= 1'b0;
                rd_data <= shreg;
                if (!hold_r) ss_n_r <= '1;
            end
        end
    end

`ifdef SPI_MNRCH_WRT_ERR_EN
    // One-cycle flag for each request that was dropped.
    always_ff @(posedge clk) begin
        if (rst) wrt_err <= 1'b0;
        else     wrt_err <= wrt && !accept;
    end
`endif

    assign SCLK      = div[DIV_W-1];
    assign MOSI      = shreg[DATA_W-1];
    assign SS_n      = ss_n_r;
    assign state_dbg = state;

endmodule
